// File: rtl/sha256_pcpi_sequencer.sv
// sha256_pcpi_sequencer
//   PCPI initiator that feeds one 512-bit block to a picorv32_pcpi_sha256
//   style coprocessor. Each request issues: [reset], 16 word loads,
//   init/next, then 8 digest reads. It returns the 256-bit running digest.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start, first      request pulse (IDLE only); first=1 -> reset+init, 0 -> next
//   block[511:0]      message block, word 0 in [511:480], latched at start
//   busy, done, error request in flight / completion pulse / fault pulse
//   digest[255:0]     H0..H7, H0 in [255:224]; updated only on done
//   pcpi_valid/insn/rs1/rs2   registered instruction request
//   pcpi_wr/rd/wait/ready     responder handshake (wait is informational)
module sha256_pcpi_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         first,
    input  logic [511:0] block,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [255:0] digest,
    output logic         pcpi_valid,
    output logic [31:0]  pcpi_insn,
    output logic [31:0]  pcpi_rs1,
    output logic [31:0]  pcpi_rs2,
    input  logic         pcpi_wr,
    input  logic [31:0]  pcpi_rd,
    input  logic         pcpi_wait,
    input  logic         pcpi_ready
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE, S_ERR} state_t;
    // P_FIN marks "all instructions issued"; the GAP after DIG 7 sees it.
    typedef enum logic [2:0] {P_RST, P_LOAD, P_CMD, P_DIG, P_FIN} phase_t;

    state_t state, state_n;
    phase_t phase, phase_n;
    logic [3:0]   idx, idx_n;
    logic         first_q, first_n;
    logic [511:0] blk;
    logic [TW-1:0] tcnt;
    logic [0:7][31:0] shadow;   // element 0 = H0, maps straight onto digest

    logic [15:0][31:0] src_w;   // element 15 = word 0
    logic [2:0]   f3;
    logic [31:0]  insn_n, rs1_n, rs2_n;

    // pcpi_wait carries no information the sequencer needs.
    logic unused_wait;
    assign unused_wait = pcpi_wait;

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    // ---------------------------------------------------------------
    // Next state / phase sequencing
    // ---------------------------------------------------------------
    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ISSUE;
                    phase_n = first ? P_RST : P_LOAD;
                    idx_n   = 4'd0;
                end
            end
            S_ISSUE: begin
                if (pcpi_ready) begin
                    if (phase == P_DIG && !pcpi_wr) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_GAP;
                        case (phase)
                            P_RST:  begin phase_n = P_LOAD; idx_n = 4'd0; end
                            P_LOAD: begin
                                if (idx == 4'd15) begin
                                    phase_n = P_CMD;
                                    idx_n   = 4'd0;
                                end else begin
                                    idx_n = idx + 4'd1;
                                end
                            end
                            P_CMD:  begin phase_n = P_DIG; idx_n = 4'd0; end
                            P_DIG: begin
                                if (idx == 4'd7) begin
                                    phase_n = P_FIN;
                                    idx_n   = 4'd0;
                                end else begin
                                    idx_n = idx + 4'd1;
                                end
                            end
                            default: phase_n = P_FIN;
                        endcase
                    end
                end else if (tcnt == TMAX) begin
                    state_n = S_ERR;
                end
            end
            S_GAP:   state_n = (phase == P_FIN) ? S_DONE : S_ISSUE;
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            phase <= P_RST;
            idx   <= 4'd0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            idx   <= idx_n;
        end
    end

    // ---------------------------------------------------------------
    // Instruction encoding for the instruction about to be issued.
    // Leaving IDLE the block/first latches are not loaded yet, so the
    // live inputs are used for that one edge.
    // ---------------------------------------------------------------
    assign src_w   = (state == S_IDLE) ? block : blk;
    assign first_n = (state == S_IDLE) ? first : first_q;

    always_comb begin
        f3    = 3'b000;
        rs1_n = '0;
        rs2_n = '0;
        case (phase_n)
            P_RST:  f3 = 3'b100;
            P_LOAD: begin
                f3    = 3'b000;
                rs1_n = src_w[4'd15 - idx_n];
                rs2_n = {28'd0, idx_n};
            end
            P_CMD:  f3 = first_n ? 3'b001 : 3'b010;
            P_DIG: begin
                f3    = 3'b011;
                rs2_n = {28'd0, idx_n};
            end
            default: f3 = 3'b000;
        endcase
        insn_n = {7'd0, 5'd0, 5'd0, f3, 5'd0, OPC_CUSTOM0};
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q    <= 1'b0;
            blk        <= '0;
            tcnt       <= '0;
            shadow     <= '0;
            digest     <= '0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                blk     <= block;
                first_q <= first;
            end

            if (state_n == S_ISSUE && state != S_ISSUE)
                tcnt <= '0;
            else if (state == S_ISSUE && !pcpi_ready)
                tcnt <= tcnt + 1'b1;

            if (state == S_ISSUE && pcpi_ready && phase == P_DIG && pcpi_wr)
                shadow[idx[2:0]] <= pcpi_rd;

            // Publish on entry to DONE so digest is already valid in the done cycle.
            if (state_n == S_DONE)
                digest <= shadow;

            // Outputs are driven only while ISSUE; zero in GAP and elsewhere.
            if (state_n == S_ISSUE) begin
                pcpi_valid <= 1'b1;
                pcpi_insn  <= insn_n;
                pcpi_rs1   <= rs1_n;
                pcpi_rs2   <= rs2_n;
            end else begin
                pcpi_valid <= 1'b0;
                pcpi_insn  <= '0;
                pcpi_rs1   <= '0;
                pcpi_rs2   <= '0;
            end
        end
    end

endmodule
